bias_add_stage: RTL and testbench
=================================

BIAS_ADD_STAGE -- requirements
Module: bias_add_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  one-cycle job-start pulse; honoured only in IDLE.
REQ-005 num_ch_i  input  9  number of output channels; sampled with start_i.
REQ-006 pix_per_ch_i  input  16  accumulator beats per channel; sampled with start_i.
REQ-007 bias_cs_o / bias_oe_o  output  1 / 1  bias SRAM chip-select and output-enable.
REQ-008 bias_addr_o  output  9  bias SRAM word address, equal to the channel index.
REQ-009 bias_rdata_i  input  32  bias SRAM read data, valid one cycle after cs&oe with address.
REQ-010 acc_valid_i / acc_ready_o / acc_data_i  in / out / in  1 / 1 / 32  signed accumulator stream.
REQ-011 out_valid_o / out_ready_i / out_data_o  out / in / out  1 / 1 / 32  biased result stream.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 done_o  output  1  one-cycle pulse at job completion.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, WAIT, RUN, DRAIN and DONE.
REQ-015 IDLE->FETCH on start_i; IDLE->DONE on start_i when num_ch_i==0 or pix_per_ch_i==0.
REQ-016 FETCH drives bias_cs_o=bias_oe_o=1 with bias_addr_o=ch_cnt for exactly one cycle, then goes to WAIT.
REQ-017 WAIT latches bias_rdata_i into bias_reg, then goes to RUN; cs/oe are 0 in every state except FETCH.
REQ-018 acc_ready_o SHALL be (state==RUN) && (!out_valid_o || out_ready_i), and is 0 in all other states.
REQ-019 On each accepted beat (acc_valid_i && acc_ready_o), out_data_o <= sat32(acc_data_i + bias_reg) and out_valid_o <= 1 on the next edge.
REQ-020 sat32 SHALL form the 33-bit signed sum and clamp it to 0x7FFFFFFF or 0x80000000 on overflow.
REQ-021 out_valid_o SHALL clear when out_ready_i is high and no new beat is accepted that cycle.
REQ-022 out_data_o SHALL be held stable while out_valid_o && !out_ready_i.
REQ-023 pix_cnt SHALL increment per accepted beat; on the beat with pix_cnt==pix_per_ch-1 it clears and the channel ends.
REQ-024 Channel end with ch_cnt<num_ch-1: ch_cnt++, RUN->FETCH; the output register keeps its pending beat across the bias refetch.
REQ-025 Channel end with ch_cnt==num_ch-1: RUN->DRAIN.
REQ-026 DRAIN->DONE in the first cycle in which out_valid_o==0, either already clear or cleared by a handshake.
REQ-027 DONE asserts done_o for one cycle, then goes to IDLE.
REQ-028 start_i outside IDLE SHALL be ignored.
REQ-029 Throughput SHALL be one beat per cycle in RUN while out_ready_i is held high.
REQ-030 Each channel change SHALL cost exactly 2 bubble cycles (FETCH, WAIT).

Reset
REQ-031 On rstn low: state=IDLE; ch_cnt, pix_cnt, bias_reg and out_data_o = 0; out_valid_o, acc_ready_o, bias_cs_o, bias_oe_o, busy_o, done_o = 0.
REQ-032 Reset asserted mid-job SHALL abandon the job and discard the pending output beat, without a done_o pulse.

Configuration
REQ-033 With macro BIAS_RELU_EN defined, a negative saturated sum SHALL be output as 0 (ReLU after saturation, same latency).
REQ-034 Without BIAS_RELU_EN, the saturated sum SHALL pass unmodified.

Verification
REQ-035 num_ch=2, pix=3, bias[0]=10, bias[1]=-5, acc=1,2,3,4,5,6, out_ready=1 -> out 11,12,13,-1,0,1, with 2 bubbles between beats 3 and 4, then done_o one pulse.
REQ-036 bias=1, acc=0x7FFFFFFF -> out 0x7FFFFFFF; bias=-1, acc=0x80000000 -> out 0x80000000.
REQ-037 BIAS_RELU_EN defined, bias=-20, acc=5 -> out 0; macro undefined -> out 0xFFFFFFF1.
REQ-038 out_ready_i low for 4 cycles mid-stream -> acc_ready_o low, out_data_o stable, no beat lost or duplicated; done_o only after the last beat handshakes.
REQ-039 num_ch=0 start -> busy_o for 1 cycle (DONE), done_o pulse, no SRAM access; start_i during RUN ignored.
REQ-040 rstn low during RUN of channel 1 -> all outputs reset values next cycle, no done_o; a new start then processes from channel 0.

Source files
------------

// File: rtl/bias_add_stage.sv
// -----------------------------------------------------------------------------
// bias_add_stage
//
// Purpose:
//   Adds a per-channel 32-bit bias to a stream of signed 32-bit accumulator
//   beats. The bias for each channel is fetched from an external SRAM, one
//   word per channel at address == channel index. Every sum is saturated to
//   the signed 32-bit range. A job covers num_ch channels of pix_per_ch beats
//   each. One beat per cycle is sustained inside a channel. Each channel
//   change costs two bubble cycles for the bias fetch.
//
// Configuration macro:
//   BIAS_RELU_EN  - when defined, negative saturated sums are output as 0.
//                   The latency does not change.
//
// Ports:
//   clk            rising-edge clock for all state
//   rstn           asynchronous active-low reset
//   start_i        one-cycle job start; only honoured while idle
//   num_ch_i       number of channels, sampled with start_i
//   pix_per_ch_i   beats per channel, sampled with start_i
//   bias_cs_o      bias SRAM chip select (asserted only during the fetch)
//   bias_oe_o      bias SRAM output enable (asserted only during the fetch)
//   bias_addr_o    bias SRAM word address (= current channel index)
//   bias_rdata_i   bias SRAM read data, valid one cycle after the fetch
//   acc_valid_i    accumulator beat valid
//   acc_ready_o    accumulator beat ready
//   acc_data_i     accumulator beat data (signed)
//   out_valid_o    biased result valid
//   out_ready_i    biased result ready
//   out_data_o     biased result data (signed, saturated)
//   busy_o         high whenever a job is in progress (any state but idle)
//   done_o         one-cycle pulse at job completion
// -----------------------------------------------------------------------------
module bias_add_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [8:0]  num_ch_i,
    input  logic [15:0] pix_per_ch_i,
    output logic        bias_cs_o,
    output logic        bias_oe_o,
    output logic [8:0]  bias_addr_o,
    input  logic [31:0] bias_rdata_i,
    input  logic        acc_valid_i,
    output logic        acc_ready_o,
    input  logic [31:0] acc_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_q,      state_d;
    logic [8:0]  ch_cnt_q,     ch_cnt_d;
    logic [15:0] pix_cnt_q,    pix_cnt_d;
    logic [8:0]  num_ch_q,     num_ch_d;
    logic [15:0] pix_per_ch_q, pix_per_ch_d;
    logic [31:0] bias_q,       bias_d;
    logic [31:0] out_data_q,   out_data_d;
    logic        out_valid_q,  out_valid_d;

    // -------------------------------------------------------------------------
    // Saturating add
    // -------------------------------------------------------------------------
    // The sum is formed at 33 bits. Overflow shows up as a disagreement
    // between the two top bits. Bit 32 then holds the true sign and picks
    // the clamp direction.
    logic [32:0] sum_wide;
    logic [31:0] sum_sat;
    logic [31:0] sum_final;

    assign sum_wide = {acc_data_i[31], acc_data_i} + {bias_q[31], bias_q};

    always_comb begin
        sum_sat = sum_wide[31:0];
        if (sum_wide[32] != sum_wide[31]) begin
            sum_sat = sum_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

`ifdef BIAS_RELU_EN
    // ReLU is applied after saturation. A clamped negative sum therefore
    // also becomes 0.
    assign sum_final = sum_sat[31] ? 32'h0000_0000 : sum_sat;
`else
    assign sum_final = sum_sat;
`endif

    // -------------------------------------------------------------------------
    // Handshake and channel/pixel boundary decode
    // -------------------------------------------------------------------------
    logic acc_fire;
    logic last_pix;
    logic last_ch;

    // A beat can be taken in RUN when the output register is free, or when
    // it is being emptied this same cycle.
    assign acc_ready_o = (state_q == ST_RUN) && (!out_valid_q || out_ready_i);
    assign acc_fire    = acc_valid_i && acc_ready_o;
    assign last_pix    = (pix_cnt_q == (pix_per_ch_q - 16'd1));
    assign last_ch     = (ch_cnt_q == (num_ch_q - 9'd1));

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        ch_cnt_d     = ch_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        num_ch_d     = num_ch_q;
        pix_per_ch_d = pix_per_ch_q;
        bias_d       = bias_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;

        // The output register is handled on its own, independent of the FSM
        // state. A beat that is pending when a channel ends stays in the
        // register through FETCH and WAIT. It may drain there.
        if (acc_fire) begin
            out_data_d  = sum_final;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    num_ch_d     = num_ch_i;
                    pix_per_ch_d = pix_per_ch_i;
                    ch_cnt_d     = 9'd0;
                    pix_cnt_d    = 16'd0;
                    // An empty job skips straight to completion. It never
                    // touches the SRAM.
                    if ((num_ch_i == 9'd0) || (pix_per_ch_i == 16'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // The read data arrives in the cycle after the fetch
                // strobe.
                bias_d  = bias_rdata_i;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (acc_fire) begin
                    if (last_pix) begin
                        pix_cnt_d = 16'd0;
                        if (last_ch) begin
                            state_d = ST_DRAIN;
                        end else begin
                            ch_cnt_d = ch_cnt_q + 9'd1;
                            state_d  = ST_FETCH;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 16'd1;
                    end
                end
            end

            ST_DRAIN: begin
                // Leave as soon as the output register is empty. That is
                // either now, or at this edge through a handshake. Nothing
                // can refill it here, because acc_ready_o is low.
                if (!out_valid_q || out_ready_i) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            ch_cnt_q     <= 9'd0;
            pix_cnt_q    <= 16'd0;
            num_ch_q     <= 9'd0;
            pix_per_ch_q <= 16'd0;
            bias_q       <= 32'd0;
            out_data_q   <= 32'd0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_cnt_q     <= ch_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            num_ch_q     <= num_ch_d;
            pix_per_ch_q <= pix_per_ch_d;
            bias_q       <= bias_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bias_cs_o   = (state_q == ST_FETCH);
    assign bias_oe_o   = (state_q == ST_FETCH);
    assign bias_addr_o = ch_cnt_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_bias_add_stage.sv
module tb_bias_add_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_i;
    logic [8:0]  num_ch_i;
    logic [15:0] pix_per_ch_i;
    logic        bias_cs_o;
    logic        bias_oe_o;
    logic [8:0]  bias_addr_o;
    logic [31:0] bias_rdata_i;
    logic        acc_valid_i;
    logic        acc_ready_o;
    logic [31:0] acc_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        busy_o;
    logic        done_o;

    always #5 clk = ~clk;

    bias_add_stage dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start_i),
        .num_ch_i     (num_ch_i),
        .pix_per_ch_i (pix_per_ch_i),
        .bias_cs_o    (bias_cs_o),
        .bias_oe_o    (bias_oe_o),
        .bias_addr_o  (bias_addr_o),
        .bias_rdata_i (bias_rdata_i),
        .acc_valid_i  (acc_valid_i),
        .acc_ready_o  (acc_ready_o),
        .acc_data_i   (acc_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    // Bias SRAM model: synchronous read, one cycle after cs&oe.
    logic [31:0] bias_mem [0:511];
    always @(posedge clk) begin
        if (bias_cs_o && bias_oe_o) bias_rdata_i <= bias_mem[bias_addr_o];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] acc_vec [0:15];
    logic [31:0] exp_vec [0:15];
    logic [31:0] got_data [$];
    int          got_cyc  [$];
    int done_cnt, done_cyc, sram_acc, busy_cnt, stall_ready_bad, stall_unstable;
    int first_addr, timed_out;

    // Runs one job: start pulse, then the accumulator stream, with optional
    // out_ready stall window and optional extra start pulse. It records what
    // the DUT emits. The checks are done by the calling test.
    task automatic drive_job(input int nch, input int pix, input int nbeats,
                             input int stall_at, input int stall_len,
                             input int restart_cyc);
        int          idx;
        logic [31:0] held;
        bit          have_held;
        bit          stalled;
        got_data.delete();
        got_cyc.delete();
        done_cnt = 0; done_cyc = 0; sram_acc = 0; busy_cnt = 0;
        stall_ready_bad = 0; stall_unstable = 0; first_addr = -1; timed_out = 0;
        idx = 0; have_held = 0; held = '0;
        @(negedge clk);
        start_i      = 1'b1;
        num_ch_i     = nch[8:0];
        pix_per_ch_i = pix[15:0];
        out_ready_i  = 1'b1;
        acc_valid_i  = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start_i = (cyc == restart_cyc);
            if (cyc == restart_cyc) begin
                num_ch_i     = 9'd5;
                pix_per_ch_i = 16'd9;
            end
            stalled     = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            out_ready_i = !stalled;
            acc_valid_i = (idx < nbeats);
            acc_data_i  = acc_vec[(idx < nbeats) ? idx : 0];
            #1;
            if (bias_cs_o) begin
                sram_acc++;
                if (first_addr < 0) first_addr = int'(bias_addr_o);
            end
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stalled && acc_ready_o) stall_ready_bad++;
            if (stalled && out_valid_o) begin
                if (have_held && (out_data_o !== held)) stall_unstable++;
                held = out_data_o;
                have_held = 1;
            end else begin
                have_held = 0;
            end
            if (out_valid_o && out_ready_i) begin
                got_data.push_back(out_data_o);
                got_cyc.push_back(cyc);
                $display("  beat %0d: out_data=0x%08h at cycle %0d", got_data.size() - 1, out_data_o, cyc);
            end
            if (acc_valid_i && acc_ready_o) idx++;
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
        end
        if (done_cnt == 0) timed_out = 1;
        acc_valid_i = 1'b0;
        start_i     = 1'b0;
        out_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start_i = 1'b0; num_ch_i = '0; pix_per_ch_i = '0;
        acc_valid_i = 1'b0; acc_data_i = '0; out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bias_cs_o, bias_oe_o, acc_ready_o, out_valid_o, busy_o, done_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bias_cs_o, bias_oe_o, acc_ready_o, out_valid_o, busy_o, done_o});
        end
        n_checks++;
        if (out_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got 0x%08h expected 0x00000000", out_data_o);
        end
        n_checks++;
        if (bias_addr_o !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d expected 0", bias_addr_o);
        end
        rstn = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_two_channel;
        bias_mem[0] = 32'd10;
        bias_mem[1] = 32'hFFFF_FFFB; // -5
        for (int i = 0; i < 6; i++) acc_vec[i] = 32'(i + 1);
        exp_vec[0] = 32'd11; exp_vec[1] = 32'd12; exp_vec[2] = 32'd13;
        exp_vec[3] = 32'hFFFF_FFFF; exp_vec[4] = 32'd0; exp_vec[5] = 32'd1;
        drive_job(2, 3, 6, -1, 0, -1);
        n_checks++;
        if (timed_out != 0 || got_data.size() != 6) begin
            n_fail++;
            $display("FAIL two_ch_count: got %0d beats timeout=%0d expected 6 beats", got_data.size(), timed_out);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_data[i] !== exp_vec[i]) begin
                    n_fail++;
                    $display("FAIL two_ch_beat%0d: got 0x%08h expected 0x%08h", i, got_data[i], exp_vec[i]);
                end
            end
            n_checks++;
            if (got_cyc[1] - got_cyc[0] != 1 || got_cyc[2] - got_cyc[1] != 1) begin
                n_fail++;
                $display("FAIL two_ch_throughput: gaps %0d %0d expected 1 1", got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]);
            end
            n_checks++;
            if (got_cyc[3] - got_cyc[2] != 3) begin
                n_fail++;
                $display("FAIL two_ch_bubbles: gap %0d expected 3", got_cyc[3] - got_cyc[2]);
            end
            n_checks++;
            if (done_cnt != 1 || done_cyc <= got_cyc[5]) begin
                n_fail++;
                $display("FAIL two_ch_done: count %0d at %0d expected 1 after %0d", done_cnt, done_cyc, got_cyc[5]);
            end
        end
        n_checks++;
        if (sram_acc != 2) begin
            n_fail++;
            $display("FAIL two_ch_sram: got %0d fetches expected 2", sram_acc);
        end
        $display("test_two_channel done");
    endtask

    task automatic test_saturation;
        logic [31:0] e_pos, e_neg;
        e_pos = 32'h7FFF_FFFF;
`ifdef BIAS_RELU_EN
        e_neg = 32'h0000_0000;
`else
        e_neg = 32'h8000_0000;
`endif
        bias_mem[0] = 32'd1;
        acc_vec[0] = 32'h7FFF_FFFF; acc_vec[1] = 32'h7FFF_FFFE;
        drive_job(1, 2, 2, -1, 0, -1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_data.size() != 2 || got_data[i] !== e_pos) begin
                n_fail++;
                $display("FAIL sat_pos%0d: got 0x%08h (%0d beats) expected 0x%08h", i,
                         (got_data.size() > i) ? got_data[i] : 32'hDEAD_DEAD, got_data.size(), e_pos);
            end
        end
        bias_mem[0] = 32'hFFFF_FFFF;
        acc_vec[0] = 32'h8000_0000; acc_vec[1] = 32'h8000_0001;
        drive_job(1, 2, 2, -1, 0, -1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_data.size() != 2 || got_data[i] !== e_neg) begin
                n_fail++;
                $display("FAIL sat_neg%0d: got 0x%08h (%0d beats) expected 0x%08h", i,
                         (got_data.size() > i) ? got_data[i] : 32'hDEAD_DEAD, got_data.size(), e_neg);
            end
        end
        $display("test_saturation done");
    endtask

    task automatic test_relu;
        logic [31:0] e;
`ifdef BIAS_RELU_EN
        e = 32'h0000_0000;
`else
        e = 32'hFFFF_FFF1;
`endif
        bias_mem[0] = 32'hFFFF_FFEC; // -20
        acc_vec[0]  = 32'd5;
        drive_job(1, 1, 1, -1, 0, -1);
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== e) begin
            n_fail++;
            $display("FAIL relu: got 0x%08h (%0d beats) expected 0x%08h",
                     (got_data.size() > 0) ? got_data[0] : 32'hDEAD_DEAD, got_data.size(), e);
        end
        $display("test_relu done");
    endtask

    task automatic test_backpressure;
        bias_mem[0] = 32'd7;
        for (int i = 0; i < 6; i++) acc_vec[i] = 32'(100 + i);
        drive_job(1, 6, 6, 4, 4, -1);
        n_checks++;
        if (got_data.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats expected 6", got_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_data[i] !== 32'(107 + i)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %0d expected %0d", i, got_data[i], 107 + i);
                end
            end
            n_checks++;
            if (done_cnt != 1 || done_cyc <= got_cyc[5]) begin
                n_fail++;
                $display("FAIL bp_done: count %0d at %0d expected 1 after %0d", done_cnt, done_cyc, got_cyc[5]);
            end
        end
        n_checks++;
        if (stall_ready_bad != 0 || stall_unstable != 0) begin
            n_fail++;
            $display("FAIL bp_stall: ready_during_stall=%0d data_changes=%0d expected 0 0", stall_ready_bad, stall_unstable);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_empty_job;
        drive_job(0, 5, 0, -1, 0, -1);
        n_checks++;
        if (done_cnt != 1 || busy_cnt != 1 || sram_acc != 0 || got_data.size() != 0) begin
            n_fail++;
            $display("FAIL empty_nch: done=%0d busy=%0d sram=%0d beats=%0d expected 1 1 0 0",
                     done_cnt, busy_cnt, sram_acc, got_data.size());
        end
        drive_job(3, 0, 0, -1, 0, -1);
        n_checks++;
        if (done_cnt != 1 || busy_cnt != 1 || sram_acc != 0 || got_data.size() != 0) begin
            n_fail++;
            $display("FAIL empty_pix: done=%0d busy=%0d sram=%0d beats=%0d expected 1 1 0 0",
                     done_cnt, busy_cnt, sram_acc, got_data.size());
        end
        $display("test_empty_job done");
    endtask

    task automatic test_start_ignored;
        bias_mem[0] = 32'd3;
        for (int i = 0; i < 4; i++) acc_vec[i] = 32'(i + 1);
        drive_job(1, 4, 4, -1, 0, 3);
        n_checks++;
        if (got_data.size() != 4 || done_cnt != 1 || sram_acc != 1) begin
            n_fail++;
            $display("FAIL restart_shape: beats=%0d done=%0d sram=%0d expected 4 1 1",
                     got_data.size(), done_cnt, sram_acc);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_data[i] !== 32'(i + 4)) begin
                    n_fail++;
                    $display("FAIL restart_beat%0d: got %0d expected %0d", i, got_data[i], i + 4);
                end
            end
        end
        $display("test_start_ignored done");
    endtask

    task automatic test_reset_mid_job;
        int  idx;
        int  done_seen;
        bias_mem[0] = 32'd10;
        bias_mem[1] = 32'hFFFF_FFFB;
        for (int i = 0; i < 6; i++) acc_vec[i] = 32'(i + 1);
        idx = 0; done_seen = 0;
        @(negedge clk);
        start_i = 1'b1; num_ch_i = 9'd2; pix_per_ch_i = 16'd3; out_ready_i = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            start_i     = 1'b0;
            acc_valid_i = 1'b1;
            acc_data_i  = acc_vec[idx];
            #1;
            if (done_o) done_seen++;
            if (acc_ready_o) idx++;
            if (idx == 4) break;
        end
        n_checks++;
        if (idx != 4) begin
            n_fail++;
            $display("FAIL rst_mid_reach: accepted %0d beats expected 4", idx);
        end
        // Beat 3 (first of channel 1) is taken at the next edge; reset while in RUN.
        @(negedge clk);
        acc_valid_i = 1'b0;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({bias_cs_o, bias_oe_o, acc_ready_o, out_valid_o, busy_o, done_o} !== 6'b0 ||
            out_data_o !== 32'd0 || bias_addr_o !== 9'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: ctrl=%b data=0x%08h addr=%0d expected 000000 0 0",
                     {bias_cs_o, bias_oe_o, acc_ready_o, out_valid_o, busy_o, done_o}, out_data_o, bias_addr_o);
        end
        repeat (2) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_done: got %0d done pulses expected 0", done_seen);
        end
        acc_vec[0] = 32'd7; acc_vec[1] = 32'd8;
        drive_job(1, 2, 2, -1, 0, -1);
        n_checks++;
        if (first_addr != 0 || got_data.size() != 2 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL rst_mid_restart: addr=%0d beats=%0d done=%0d expected 0 2 1",
                     first_addr, got_data.size(), done_cnt);
        end else begin
            n_checks++;
            if (got_data[0] !== 32'd17 || got_data[1] !== 32'd18) begin
                n_fail++;
                $display("FAIL rst_mid_data: got %0d %0d expected 17 18", got_data[0], got_data[1]);
            end
        end
        $display("test_reset_mid_job done");
    endtask

    initial begin
        test_reset();
        test_two_channel();
        test_saturation();
        test_relu();
        test_backpressure();
        test_empty_job();
        test_start_ignored();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
